prga: RTL and testbench

RC4 pseudo-random generation and decrypt engine: the reader of the S-box that `init`/`ksa` write. Starting from a keyed 256-byte S memory, it walks the PRGA, XORs each keystream byte with a length-prefixed ciphertext, and writes the plaintext into a third memory. It sits beside `ksa` under the `arc4` top and is started with the lab's `en`/`rdy` handshake.

---
 rtl/arc4_pkg.sv | 36 +++
 rtl/prga.sv | 192 +++++++++++++++++++
 tb/tb_prga.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared RC4 definitions: byte/S-box geometry, printable range and the
// PRGA state encoding.
package arc4_pkg;

    localparam int BYTE_W  = 8;
    localparam int S_DEPTH = 256;
    localparam int ADDR_W  = $clog2(S_DEPTH);

    localparam logic [BYTE_W-1:0] PRINT_LO = 8'h20;
    localparam logic [BYTE_W-1:0] PRINT_HI = 8'h7E;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [3:0] {
        IDLE,
        LEN_RD,
        LEN_WAIT,
        LEN_LATCH,
        READ_I,
        WAIT_I,
        READ_J,
        WAIT_J,
        SWAP_I,
        SWAP_J,
        READ_P,
        WAIT_P,
        WRITE_PT
    } prga_state_t;

    // True when a plaintext byte lies in the printable ASCII window.
    function automatic logic is_printable(input byte_t b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/prga.sv
// RC4 PRGA / decrypt engine. Reads a length-prefixed ciphertext, walks the
// keystream over the keyed S memory (swapping in place) and writes the
// length-prefixed plaintext. All memory-facing outputs are registered, so an
// address issued in state X is seen by the RAM during the following state
// and its data returns one cycle after that.
// Optional: PRGA_PRINTABLE_CHECK_EN adds the sticky non-printable flag 'bad';
// without it 'bad' is tied low.
module prga
    import arc4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [BYTE_W-1:0] s_addr,
    input  logic [BYTE_W-1:0] s_rddata,
    output logic [BYTE_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [BYTE_W-1:0] ct_addr,
    input  logic [BYTE_W-1:0] ct_rddata,
    output logic [BYTE_W-1:0] pt_addr,
    output logic [BYTE_W-1:0] pt_wrdata,
    output logic              pt_wren,
    output logic              bad
);

    prga_state_t state, state_d;

    // Datapath registers: RC4 indices, message length/position, latched bytes.
    byte_t i_q, j_q, k_q, len_q, si_q, sj_q, ctb_q;
    byte_t i_d, j_d, k_d, len_d, si_d, sj_d, ctb_d;

    // Next values of the registered memory-port outputs.
    byte_t s_addr_d, s_wrdata_d, ct_addr_d, pt_addr_d, pt_wrdata_d;
    logic  s_wren_d, pt_wren_d;
    byte_t pt_byte;

`ifdef PRGA_PRINTABLE_CHECK_EN
    logic bad_q, bad_d;
    assign bad = bad_q;
`else
    assign bad = 1'b0;
`endif

    assign rdy     = (state == IDLE);
    assign pt_byte = s_rddata ^ ctb_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic: a fixed 9-state walk per byte after a 3-state length read.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:      if (en) state_d = LEN_RD;
            LEN_RD:    state_d = LEN_WAIT;
            LEN_WAIT:  state_d = LEN_LATCH;
            LEN_LATCH: state_d = (ct_rddata == '0) ? IDLE : READ_I;
            READ_I:    state_d = WAIT_I;
            WAIT_I:    state_d = READ_J;
            READ_J:    state_d = WAIT_J;
            WAIT_J:    state_d = SWAP_I;
            SWAP_I:    state_d = SWAP_J;
            SWAP_J:    state_d = READ_P;
            READ_P:    state_d = WAIT_P;
            WAIT_P:    state_d = WRITE_PT;
            WRITE_PT:  state_d = (k_q == len_q) ? IDLE : READ_I;
            default:   state_d = IDLE;
        endcase
    end

    // Output/datapath logic: next values for every registered output and index.
    // Write enables default low so each write is a single-cycle pulse. When
    // i==j the two swap writes carry the same byte, leaving S unchanged.
    always_comb begin
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        len_d       = len_q;
        si_d        = si_q;
        sj_d        = sj_q;
        ctb_d       = ctb_q;
        s_addr_d    = s_addr;
        s_wrdata_d  = s_wrdata;
        s_wren_d    = 1'b0;
        ct_addr_d   = ct_addr;
        pt_addr_d   = pt_addr;
        pt_wrdata_d = pt_wrdata;
        pt_wren_d   = 1'b0;
`ifdef PRGA_PRINTABLE_CHECK_EN
        bad_d       = bad_q;
`endif
        case (state)
            IDLE: begin
                if (en) begin
                    i_d = '0;
                    j_d = '0;
                    k_d = '0;
`ifdef PRGA_PRINTABLE_CHECK_EN
                    bad_d = 1'b0;
`endif
                end
            end
            LEN_RD: ct_addr_d = '0;
            LEN_LATCH: begin
                len_d       = ct_rddata;
                pt_addr_d   = '0;
                pt_wrdata_d = ct_rddata;
                pt_wren_d   = 1'b1;
                k_d         = 8'd1;
            end
            READ_I: begin
                i_d       = i_q + 8'd1;
                s_addr_d  = i_q + 8'd1;
                ct_addr_d = k_q;
            end
            READ_J: begin
                si_d     = s_rddata;
                ctb_d    = ct_rddata;
                j_d      = j_q + s_rddata;
                s_addr_d = j_q + s_rddata;
            end
            SWAP_I: begin
                sj_d       = s_rddata;
                s_addr_d   = i_q;
                s_wrdata_d = s_rddata;
                s_wren_d   = 1'b1;
            end
            SWAP_J: begin
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
            end
            READ_P: s_addr_d = si_q + sj_q;
            WRITE_PT: begin
                pt_addr_d   = k_q;
                pt_wrdata_d = pt_byte;
                pt_wren_d   = 1'b1;
                if (k_q != len_q) k_d = k_q + 8'd1;
`ifdef PRGA_PRINTABLE_CHECK_EN
                if (!is_printable(pt_byte)) bad_d = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            len_q     <= '0;
            si_q      <= '0;
            sj_q      <= '0;
            ctb_q     <= '0;
            s_addr    <= '0;
            s_wrdata  <= '0;
            s_wren    <= 1'b0;
            ct_addr   <= '0;
            pt_addr   <= '0;
            pt_wrdata <= '0;
            pt_wren   <= 1'b0;
`ifdef PRGA_PRINTABLE_CHECK_EN
            bad_q     <= 1'b0;
`endif
        end else begin
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            len_q     <= len_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            ctb_q     <= ctb_d;
            s_addr    <= s_addr_d;
            s_wrdata  <= s_wrdata_d;
            s_wren    <= s_wren_d;
            ct_addr   <= ct_addr_d;
            pt_addr   <= pt_addr_d;
            pt_wrdata <= pt_wrdata_d;
            pt_wren   <= pt_wren_d;
`ifdef PRGA_PRINTABLE_CHECK_EN
            bad_q     <= bad_d;
`endif
        end
    end

endmodule

// File: tb/tb_prga.sv
// Bench for prga: synchronous-read memory models for S/CT/PT, a plain RC4
// reference computed from the loaded contents, and a per-cycle compare of
// every plaintext write against the reference stream.
module tb_prga;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       rdy, s_wren, pt_wren, bad;
    logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;

    logic [7:0] smem [256];
    logic [7:0] ctmem[256];
    logic [7:0] ptmem[256];
    logic [7:0] ld_s [256];
    logic [7:0] ld_ct[256];
    logic [7:0] ms   [256];
    logic [7:0] mpt  [256];

    logic       tb_we   = 1'b0;
    logic [7:0] tb_addr = 8'h00;

    int          checks = 0;
    int          errors = 0;
    bit          chk_on = 1'b0;
    int          s_wr_cnt, pt_wr_cnt;
    logic [15:0] exp_q[$];
    logic [15:0] cmp_e;
    int          exp_len;
    bit          exp_bad;

`ifdef PRGA_PRINTABLE_CHECK_EN
    localparam bit CHK_PRINT = 1'b1;
`else
    localparam bit CHK_PRINT = 1'b0;
`endif

    prga dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren),
        .bad(bad)
    );

    always #5 clk = ~clk;

    // Memories: one-cycle registered read; bench bulk-load has priority.
    always @(posedge clk) begin
        if (tb_we) begin
            smem[tb_addr]  <= ld_s[tb_addr];
            ctmem[tb_addr] <= ld_ct[tb_addr];
            ptmem[tb_addr] <= 8'h00;
        end else begin
            if (s_wren)  smem[s_addr]   <= s_wrdata;
            if (pt_wren) ptmem[pt_addr] <= pt_wrdata;
        end
        s_rddata  <= smem[s_addr];
        ct_rddata <= ctmem[ct_addr];
    end

    task automatic chk_eq(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Per-cycle compare: write exclusivity and each PT write against the model stream.
    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk_eq("wren_exclusive", int'(s_wren && pt_wren), 0);
            if (s_wren) s_wr_cnt++;
            if (pt_wren) begin
                pt_wr_cnt++;
                if (exp_q.size() == 0) chk_eq("pt_extra_write", int'(pt_addr), -1);
                else begin
                    cmp_e = exp_q.pop_front();
                    chk_eq("pt_wr_addr", int'(pt_addr), int'(cmp_e[15:8]));
                    chk_eq("pt_wr_data", int'(pt_wrdata), int'(cmp_e[7:0]));
                end
            end
        end
    end

    task automatic load_mems();
        for (int a = 0; a < 256; a++) begin
            tb_addr = 8'(a);
            tb_we   = 1'b1;
            @(posedge clk);
            #1;
        end
        tb_we = 1'b0;
    endtask

    task automatic set_identity();
        for (int a = 0; a < 256; a++) ld_s[a] = 8'(a);
    endtask

    task automatic set_ksa(input logic [23:0] key);
        int jj;
        logic [7:0] t, kb;
        set_identity();
        jj = 0;
        for (int a = 0; a < 256; a++) begin
            kb = key[8*(2 - (a % 3)) +: 8];
            jj = (jj + ld_s[a] + kb) & 255;
            t = ld_s[a]; ld_s[a] = ld_s[jj]; ld_s[jj] = t;
        end
    endtask

    task automatic set_random_s();
        int r;
        logic [7:0] t;
        set_identity();
        for (int a = 255; a > 0; a--) begin
            r = $urandom_range(a, 0);
            t = ld_s[a]; ld_s[a] = ld_s[r]; ld_s[r] = t;
        end
    endtask

    // Plain RC4 over the loaded S/CT: expected PT, final S, bad flag, write stream.
    task automatic model_run();
        int ii, jj, p;
        logic [7:0] t;
        exp_q.delete();
        exp_len = int'(ld_ct[0]);
        exp_bad = 1'b0;
        for (int a = 0; a < 256; a++) begin ms[a] = ld_s[a]; mpt[a] = 8'h00; end
        mpt[0] = ld_ct[0];
        exp_q.push_back({8'h00, ld_ct[0]});
        ii = 0; jj = 0;
        for (int k = 1; k <= exp_len; k++) begin
            ii = (ii + 1) & 255;
            jj = (jj + ms[ii]) & 255;
            t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
            p = int'(ms[(ms[ii] + ms[jj]) & 255] ^ ld_ct[k]);
            mpt[k] = 8'(p);
            exp_q.push_back({8'(k), 8'(p)});
            if (p < 32 || p > 126) exp_bad = 1'b1;
        end
        if (!CHK_PRINT) exp_bad = 1'b0;
    endtask

    // Start a run, optionally toggling en while busy, and return cycles E0..rdy.
    task automatic start_and_wait(input bit pulse, input int budget, output int cyc);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en  = pulse ? 1'($urandom_range(1, 0)) : 1'b0;
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk);
            cyc++;
            #1;
            if (rdy) break;
            en = pulse ? 1'($urandom_range(1, 0)) : 1'b0;
        end
        en = 1'b0;
        if (!rdy) chk_eq("rdy_timeout", cyc, -1);
    endtask

    // Full run against the reference plus end-of-run checks.
    task automatic run_check(input bit pulse);
        int cyc, bad_s, bad_p;
        model_run();
        s_wr_cnt  = 0;
        pt_wr_cnt = 0;
        chk_on    = 1'b1;
        start_and_wait(pulse, 3 + 9 * exp_len + 20, cyc);
        chk_eq("rdy_latency", cyc, 3 + 9 * exp_len);
        @(posedge clk);
        #1;
        chk_eq("bad_flag", int'(bad), int'(exp_bad));
        chk_eq("pt_stream_left", exp_q.size(), 0);
        chk_eq("s_write_count", s_wr_cnt, 2 * exp_len);
        chk_eq("pt_write_count", pt_wr_cnt, exp_len + 1);
        bad_s = 0; bad_p = 0;
        for (int a = 0; a < 256; a++) begin
            if (smem[a] !== ms[a]) bad_s++;
            if (ptmem[a] !== mpt[a]) bad_p++;
        end
        chk_eq("s_final_mismatches", bad_s, 0);
        chk_eq("pt_mem_mismatches", bad_p, 0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk_eq("rst_rdy", int'(rdy), 1);
            chk_eq("rst_wren", int'({s_wren, pt_wren}), 0);
            chk_eq("rst_bad", int'(bad), 0);
            chk_eq("rst_addr", int'({s_addr, ct_addr, pt_addr}), 0);
            chk_eq("rst_wrdata", int'({s_wrdata, pt_wrdata}), 0);
        end
        rst_n = 1'b1;
    endtask

    logic [71:0] txt;
    logic [7:0]  key_ct[10];
    int          dummy;

    initial begin
        txt = "Plaintext";
        key_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int a = 0; a < 256; a++) ld_ct[a] = 8'h00;

        do_reset(4);

        // Identity S, CT=[01,00] -> PT=[01,02].
        set_identity();
        ld_ct[0] = 8'h01; ld_ct[1] = 8'h00;
        load_mems();
        run_check(1'b0);
        chk_eq("ident_pt0", int'(ptmem[0]), 8'h01);
        chk_eq("ident_pt1", int'(ptmem[1]), 8'h02);

        // Zero-length message.
        ld_ct[0] = 8'h00;
        load_mems();
        run_check(1'b1);
        chk_eq("len0_pt0", int'(ptmem[0]), 8'h00);
        chk_eq("len0_swrites", s_wr_cnt, 0);

        // Reset while idle.
        do_reset(2);

        // KSA("Key") test vector.
        set_ksa("Key");
        for (int a = 0; a < 10; a++) ld_ct[a] = key_ct[a];
        load_mems();
        run_check(1'b1);
        for (int k = 1; k <= 9; k++)
            chk_eq("key_plaintext", int'(ptmem[k]), int'(txt[8 * (9 - k) +: 8]));

        // Abort mid-run with reset, then reload and rerun.
        load_mems();
        chk_on = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        do_reset(2);
        load_mems();
        run_check(1'b1);
        for (int k = 1; k <= 9; k++)
            chk_eq("rerun_plaintext", int'(ptmem[k]), int'(txt[8 * (9 - k) +: 8]));

        // Printable check.
        set_identity();
        for (int a = 0; a < 256; a++) ld_ct[a] = 8'h00;
        ld_ct[0] = 8'h01; ld_ct[1] = 8'h03;
        load_mems();
        run_check(1'b0);
        chk_eq("print_pt1_a", int'(ptmem[1]), 8'h01);
        chk_eq("print_bad_a", int'(bad), int'(CHK_PRINT));
        ld_ct[1] = 8'h43;
        load_mems();
        run_check(1'b0);
        chk_eq("print_pt1_b", int'(ptmem[1]), 8'h41);
        chk_eq("print_bad_b", int'(bad), 0);

        // Randomized S permutations and messages.
        for (int r = 0; r < 7; r++) begin
            set_random_s();
            for (int a = 0; a < 256; a++) ld_ct[a] = 8'($urandom_range(255, 0));
            ld_ct[0] = (r == 6) ? 8'd255 : 8'($urandom_range(24, 1));
            load_mems();
            run_check(1'b1);
        end

        dummy = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
